// File: rtl/ps2_rx_if.sv
// PS/2 receiver bus: raw keyboard lines in, scancode byte strobe and status out.
interface ps2_rx_if;
  logic       i_ps2_clk;
  logic       i_ps2_data;
  logic       o_byte_en;
  logic [7:0] o_byte;
  logic       o_err;
  logic       o_busy;

  // Keyboard side: drives the raw lines, observes the decoded bytes.
  modport master (
    output i_ps2_clk,
    output i_ps2_data,
    input  o_byte_en,
    input  o_byte,
    input  o_err,
    input  o_busy
  );

  // Receiver side.
  modport slave (
    input  i_ps2_clk,
    input  i_ps2_data,
    output o_byte_en,
    output o_byte,
    output o_err,
    output o_busy
  );
endinterface

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver. Synchronises the raw ps2_clk/ps2_data
// lines, samples data on each ps2_clk falling edge and assembles 11-bit frames
// (start, 8 data bits LSB first, odd parity, stop) into scancode bytes.
// Malformed or stalled frames produce a one-cycle error strobe instead.
module ps2_rx #(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int CNT_W          = 16
) (
  input  logic   clk,
  input  logic   i_sclr,
  ps2_rx_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  state_t             state, state_n;
  logic               ps2c_meta, ps2c_sync, ps2c_prev;
  logic               ps2d_meta, ps2d_sync;
  logic               fall;
  logic [2:0]         bitcnt, bitcnt_n;
  logic [7:0]         shift, shift_n;
  logic               parity_ok, parity_ok_n;
  logic [CNT_W-1:0]   tcnt, tcnt_n;
  logic [7:0]         byte_q, byte_n;
  logic               byte_en_q, byte_en_n;
  logic               err_q, err_n;
  logic               timeout;

  // Odd parity over data plus parity bit: a good frame has an odd count of ones.
  function automatic logic odd_parity_ok(input logic [7:0] d, input logic p);
    return ^{d, p};
  endfunction

  // Two-flop synchronisers on both lines plus the edge-history flop; idle high.
  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      ps2c_meta <= 1'b1;
      ps2c_sync <= 1'b1;
      ps2c_prev <= 1'b1;
      ps2d_meta <= 1'b1;
      ps2d_sync <= 1'b1;
    end else begin
      ps2c_meta <= bus.i_ps2_clk;
      ps2c_sync <= ps2c_meta;
      ps2c_prev <= ps2c_sync;
      ps2d_meta <= bus.i_ps2_data;
      ps2d_sync <= ps2d_meta;
    end
  end

  assign fall = ps2c_prev & ~ps2c_sync;

  // A stalled frame is abandoned only if no edge arrives in the expiring cycle.
  assign timeout = (state != IDLE) && !fall && (tcnt == CNT_W'(TIMEOUT_CYCLES - 1));

  // Next-state and datapath decode; everything holds unless a rule below fires.
  always_comb begin
    state_n     = state;
    bitcnt_n    = bitcnt;
    shift_n     = shift;
    parity_ok_n = parity_ok;
    byte_n      = byte_q;
    byte_en_n   = 1'b0;
    err_n       = 1'b0;
    tcnt_n      = (state == IDLE || fall) ? '0 : tcnt + CNT_W'(1);

    if (timeout) begin
      state_n  = IDLE;
      err_n    = 1'b1;
      shift_n  = '0;
      bitcnt_n = '0;
    end else if (fall) begin
      unique case (state)
        IDLE: begin
          if (!ps2d_sync) begin
            state_n  = DATA;
            bitcnt_n = '0;
          end
        end
        DATA: begin
          shift_n  = {ps2d_sync, shift[7:1]};
          bitcnt_n = bitcnt + 3'd1;
          if (bitcnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          parity_ok_n = odd_parity_ok(shift, ps2d_sync);
          state_n     = STOP;
        end
        STOP: begin
          if (ps2d_sync && parity_ok) begin
            byte_n    = shift;
            byte_en_n = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // State, frame assembly and registered output strobes.
  always_ff @(posedge clk or posedge i_sclr) begin
    if (i_sclr) begin
      state     <= IDLE;
      bitcnt    <= '0;
      shift     <= '0;
      parity_ok <= 1'b0;
      tcnt      <= '0;
      byte_q    <= '0;
      byte_en_q <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      bitcnt    <= bitcnt_n;
      shift     <= shift_n;
      parity_ok <= parity_ok_n;
      tcnt      <= tcnt_n;
      byte_q    <= byte_n;
      byte_en_q <= byte_en_n;
      err_q     <= err_n;
    end
  end

  assign bus.o_byte_en = byte_en_q;
  assign bus.o_byte    = byte_q;
  assign bus.o_err     = err_q;
  assign bus.o_busy    = (state != IDLE);

endmodule
